wptr_level_sync: RTL and testbench
==================================

Name: wptr_level_sync

Overview:
Write-domain receiver for the read pointer of the asynchronous FIFO. The read side Gray-encodes its pointer. This block synchronizes that pointer into wclk, decodes it back to binary, and derives the write-side fill level, free-space count, almost-full flag with hysteresis, and a sticky overflow flag.
It sits between the read-domain pointer logic and the write-pointer/full logic. Its synchronized Gray output feeds the full comparison. Level and almost-full feed upstream AXI write-channel throttling.

Parameters:
ADDRSIZE, 4, FIFO address width; DEPTH = 2**ADDRSIZE entries; pointers are ADDRSIZE+1 bits.
SYNC_STAGES, 2, number of flops in the rptr synchronizer chain; legal range 2..4.
AFULL_SET, 12, level at or above which wafull asserts; constraint AFULL_CLR < AFULL_SET <= DEPTH.
AFULL_CLR, 8, level at or below which wafull deasserts.

Ports:
wclk  in  1  write-domain clock
wrst  in  1  asynchronous active-high reset, write domain
rptr_gray  in  ADDRSIZE+1  read pointer, Gray code, launched from rclk flops
wptr_gray  in  ADDRSIZE+1  write pointer, Gray code, wclk-domain register
wpush  in  1  write request this cycle
wfull  in  1  registered full flag from write-pointer logic
wovf_clr  in  1  clears wovf
rptr_wclk  out  ADDRSIZE+1  synchronized read pointer, Gray
rbin_wclk  out  ADDRSIZE+1  synchronized read pointer, binary
wlevel  out  ADDRSIZE+1  entries occupied, 0..DEPTH
wfree  out  ADDRSIZE+1  DEPTH - wlevel
wafull  out  1  almost-full with hysteresis
wovf  out  1  sticky: push attempted while full

Behaviour:
- wrst is asynchronous and active-high. While asserted: all sync stages, rptr_wclk, rbin_wclk, wlevel, wafull and wovf are 0; wfree = DEPTH.
- Mid-operation reset: same values on the next evaluation. No partial state survives.
- Synchronizer: chain of SYNC_STAGES flops clocked by wclk; rptr_wclk is the last stage.
  - No logic between stages.
  - rptr_gray is sampled raw; never decode before synchronizing.
- Gray-to-binary decode (combinational):
  - b[ADDRSIZE] = g[ADDRSIZE]
  - b[i] = b[i+1] ^ g[i], for i down to 0
  - Applied to both rptr_wclk and wptr_gray.
- Registered each edge:
  - rbin_wclk <= dec(rptr_wclk)
  - wlevel <= (dec(wptr_gray) - dec(rptr_wclk)) mod 2**(ADDRSIZE+1)
  - wfree <= DEPTH - that same level
- Latency:
  - rptr_gray to rptr_wclk: SYNC_STAGES edges.
  - rptr_gray to rbin_wclk/wlevel/wfree: SYNC_STAGES+1 edges.
  - wptr_gray to wlevel/wfree: 1 edge.
- Wrap-around: the subtraction is modulo 2**(ADDRSIZE+1). The MSB of each pointer is the lap bit, so level is correct across pointer wrap.
- wafull, registered and based on the new level value:
  - Sets when level >= AFULL_SET.
  - Clears when level <= AFULL_CLR.
  - Otherwise holds its value.
- wlevel is pessimistic (stale rptr). It may be high but never low versus true occupancy.
- wovf:
  - Sets on any edge where wpush & wfull.
  - Clears on an edge where wovf_clr = 1 and no new set condition exists.
  - If set and clear occur in the same cycle, set wins.
  - wovf otherwise holds.
- No handshakes. All outputs update every wclk edge.

Optional Feature:
Macro WPTR_LEVEL_CHECK_EN.
- Defined: adds output wlvl_err (1 bit, reset 0), sticky.
  - Sets when the computed level exceeds DEPTH. This indicates a corrupted or non-Gray pointer crossing.
  - On that cycle, wlevel and wfree saturate to DEPTH and 0.
  - Cleared only by wrst.
- Undefined: port absent; no saturation; level is the raw modular difference.

Test Plan:
Defaults: ADDRSIZE=4, SYNC_STAGES=2, AFULL_SET=12, AFULL_CLR=8.
1. Assert wrst mid-run, including with wovf=1 and wafull=1 -> all outputs 0 except wfree=16, immediately and without a clock edge.
2. rptr_gray=0, wptr_gray=5'b00111 (bin 5) -> after 1 edge wlevel=5, wfree=11, wafull=0.
3. wptr bin 5 held; rptr_gray 0 -> 5'b00010 (bin 3) at edge N -> rptr_wclk=00010 after edge N+2; rbin_wclk=3 and wlevel=2 after edge N+3.
4. Hysteresis: wptr bin 12, rptr 0 -> wafull=1. rptr bin 3 (level 9) -> wafull stays 1. rptr bin 4 (level 8) -> wafull=0. rptr bin 1 (level 11) -> stays 0.
5. Wrap: wptr bin 2 (gray 00011), rptr bin 28 (gray 10010) -> wlevel=6, wfree=10. With WPTR_LEVEL_CHECK_EN, wptr bin 20 vs rptr bin 0 -> wlvl_err=1, wlevel=16, wfree=0.
6. Overflow:
   - wpush=1, wfull=1 for one cycle -> wovf=1 next edge and holds.
   - wovf_clr pulse -> wovf=0.
   - wpush&wfull together with wovf_clr -> wovf=1.

Source files
------------

// File: rtl/wptr_level_sync.sv
// -----------------------------------------------------------------------------
// wptr_level_sync
//
// Write-domain receiver for the asynchronous FIFO read pointer. The read side
// launches its pointer in Gray code. This block:
//   - synchronizes that pointer into wclk through a plain flop chain,
//   - decodes the synchronized pointer and the local write pointer to binary,
//   - registers the fill level, the free-space count, an almost-full flag with
//     hysteresis, and a sticky overflow flag.
//
// Because the read pointer seen here is always somewhat stale, wlevel can be
// higher than the true occupancy but never lower.
//
// Parameters
//   ADDRSIZE     FIFO address width. DEPTH = 2**ADDRSIZE. Pointers are
//                ADDRSIZE+1 bits wide; the MSB is the lap bit.
//   SYNC_STAGES  Number of flops in the rptr synchronizer (2..4).
//   AFULL_SET    Level at or above which wafull asserts.
//   AFULL_CLR    Level at or below which wafull deasserts
//                (AFULL_CLR < AFULL_SET <= DEPTH).
//
// Ports
//   wclk       in   write-domain clock
//   wrst       in   asynchronous active-high reset
//   rptr_gray  in   read pointer, Gray code, from rclk flops (sampled raw)
//   wptr_gray  in   write pointer, Gray code, wclk-domain register
//   wpush      in   write request this cycle
//   wfull      in   registered full flag
//   wovf_clr   in   clears wovf (a simultaneous overflow wins)
//   rptr_wclk  out  synchronized read pointer, Gray (last sync stage)
//   rbin_wclk  out  synchronized read pointer, binary
//   wlevel     out  entries occupied, 0..DEPTH
//   wfree      out  DEPTH - wlevel
//   wafull     out  almost-full with hysteresis
//   wovf       out  sticky: push attempted while full
//   wlvl_err   out  (only with WPTR_LEVEL_CHECK_EN) sticky flag, set when the
//                   computed level exceeds DEPTH; cleared only by wrst
//
// Optional feature macro: WPTR_LEVEL_CHECK_EN
//   When defined, the wlvl_err port is added and an out-of-range level is
//   saturated to DEPTH (wfree to 0). When undefined, the level is the raw
//   modular pointer difference.
// -----------------------------------------------------------------------------
module wptr_level_sync #(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_SET   = 12,
    parameter int AFULL_CLR   = 8
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic [ADDRSIZE:0]   rptr_gray,
    input  logic [ADDRSIZE:0]   wptr_gray,
    input  logic                wpush,
    input  logic                wfull,
    input  logic                wovf_clr,
    output logic [ADDRSIZE:0]   rptr_wclk,
    output logic [ADDRSIZE:0]   rbin_wclk,
    output logic [ADDRSIZE:0]   wlevel,
    output logic [ADDRSIZE:0]   wfree,
    output logic                wafull,
`ifdef WPTR_LEVEL_CHECK_EN
    output logic                wovf,
    output logic                wlvl_err
`else
    output logic                wovf
`endif
);

    localparam int PW = ADDRSIZE + 1;

    // DEPTH expressed in pointer width: lap bit set, address bits clear.
    localparam logic [PW-1:0] DEPTH_V = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [PW-1:0] SET_V   = PW'(AFULL_SET);
    localparam logic [PW-1:0] CLR_V   = PW'(AFULL_CLR);

    // -------------------------------------------------------------------------
    // Read-pointer synchronizer. Pure flop chain: the Gray pointer is sampled
    // raw so that at most one bit can be in transition at the first stage.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][PW-1:0] sync_reg;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            sync_reg <= '0;
        end else begin
            sync_reg[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign rptr_wclk = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Gray-to-binary decode. Each binary bit is the XOR of the Gray bits at
    // and above it, which is the closed form of b[i] = b[i+1] ^ g[i] and
    // avoids a self-referencing vector.
    // -------------------------------------------------------------------------
    logic [PW-1:0] rbin_dec;
    logic [PW-1:0] wbin_dec;

    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_decode
            assign rbin_dec[gi] = ^rptr_wclk[PW-1:gi];
            assign wbin_dec[gi] = ^wptr_gray[PW-1:gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Level / free / almost-full / overflow next-state logic
    // -------------------------------------------------------------------------
    logic [PW-1:0] level_raw;
    logic [PW-1:0] level_next;
    logic [PW-1:0] free_next;
    logic          afull_next;
    logic          ovf_next;
    logic          err_hit;

    // Modular subtraction: the lap bit makes this correct across wrap.
    assign level_raw = wbin_dec - rbin_dec;

    always_comb begin
        level_next = level_raw;
        err_hit    = 1'b0;
`ifdef WPTR_LEVEL_CHECK_EN
        // A level beyond DEPTH cannot come from a legal Gray crossing; clamp
        // so downstream throttling sees "completely full" instead of garbage.
        if (level_raw > DEPTH_V) begin
            level_next = DEPTH_V;
            err_hit    = 1'b1;
        end
`endif
        free_next = DEPTH_V - level_next;
    end

    // Hysteresis evaluated on the level being registered this edge.
    logic afull_reg;

    always_comb begin
        afull_next = afull_reg;
        if (level_next >= SET_V) begin
            afull_next = 1'b1;
        end else if (level_next <= CLR_V) begin
            afull_next = 1'b0;
        end
    end

    // Set has priority over clear so a clear pulse never hides a new overflow.
    logic ovf_reg;

    always_comb begin
        ovf_next = ovf_reg;
        if (wpush && wfull) begin
            ovf_next = 1'b1;
        end else if (wovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    logic [PW-1:0] rbin_reg;
    logic [PW-1:0] level_reg;
    logic [PW-1:0] free_reg;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            rbin_reg  <= '0;
            level_reg <= '0;
            free_reg  <= DEPTH_V;
            afull_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            rbin_reg  <= rbin_dec;
            level_reg <= level_next;
            free_reg  <= free_next;
            afull_reg <= afull_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign rbin_wclk = rbin_reg;
    assign wlevel    = level_reg;
    assign wfree     = free_reg;
    assign wafull    = afull_reg;
    assign wovf      = ovf_reg;

`ifdef WPTR_LEVEL_CHECK_EN
    logic err_reg;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            err_reg <= 1'b0;
        end else if (err_hit) begin
            err_reg <= 1'b1;
        end
    end

    assign wlvl_err = err_reg;
`else
    // Without the checker the out-of-range indication has no consumer.
    logic unused_err;
    assign unused_err = err_hit;
`endif

endmodule

// File: tb/tb_wptr_level_sync.sv
`timescale 1ns/1ps
module tb_wptr_level_sync;

    localparam int A     = 4;
    localparam int PW    = A + 1;
    localparam int SS    = 2;
    localparam int SET   = 12;
    localparam int CLR   = 8;
    localparam int DEPTH = 16;

    logic          wclk = 1'b0;
    logic          wrst;
    logic [PW-1:0] rptr_gray;
    logic [PW-1:0] wptr_gray;
    logic          wpush;
    logic          wfull;
    logic          wovf_clr;
    logic [PW-1:0] rptr_wclk;
    logic [PW-1:0] rbin_wclk;
    logic [PW-1:0] wlevel;
    logic [PW-1:0] wfree;
    logic          wafull;
    logic          wovf;
`ifdef WPTR_LEVEL_CHECK_EN
    logic          wlvl_err;
`endif

    wptr_level_sync #(
        .ADDRSIZE   (A),
        .SYNC_STAGES(SS),
        .AFULL_SET  (SET),
        .AFULL_CLR  (CLR)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .rptr_gray(rptr_gray),
        .wptr_gray(wptr_gray),
        .wpush    (wpush),
        .wfull    (wfull),
        .wovf_clr (wovf_clr),
        .rptr_wclk(rptr_wclk),
        .rbin_wclk(rbin_wclk),
        .wlevel   (wlevel),
        .wfree    (wfree),
        .wafull   (wafull),
`ifdef WPTR_LEVEL_CHECK_EN
        .wovf     (wovf),
        .wlvl_err (wlvl_err)
`else
        .wovf     (wovf)
`endif
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string         tag;
        logic [PW-1:0] rg;
        logic [PW-1:0] rb;
        logic [PW-1:0] lvl;
        logic [PW-1:0] fr;
        logic          af;
        logic          ov;
        logic          er;
    } exp_t;

    exp_t sb[$];

    // Reference state: settled pointers and flag values as the spec defines them.
    int m_w   = 0;
    int m_r   = 0;
    int m_lvl = 0;
    bit m_af  = 1'b0;
    bit m_ov  = 1'b0;
    bit m_er  = 1'b0;

    function automatic logic [PW-1:0] bin2gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input int rg, input int rb, input int lvl,
                                input bit af, input bit ov, input bit er);
        exp_t e;
        e.tag = tag;
        e.rg  = PW'(rg);
        e.rb  = PW'(rb);
        e.lvl = PW'(lvl);
        e.fr  = PW'(DEPTH - lvl);
        e.af  = af;
        e.ov  = ov;
        e.er  = er;
        return e;
    endfunction

    // Snapshot of the settled model state.
    task automatic push_model(input string tag);
        sb.push_back(mk(tag, int'(bin2gray(m_r)), m_r, m_lvl, m_af, m_ov, m_er));
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        check_val({e.tag, ".rptr_wclk"}, 32'(rptr_wclk), 32'(e.rg));
        check_val({e.tag, ".rbin_wclk"}, 32'(rbin_wclk), 32'(e.rb));
        check_val({e.tag, ".wlevel"},    32'(wlevel),    32'(e.lvl));
        check_val({e.tag, ".wfree"},     32'(wfree),     32'(e.fr));
        check_val({e.tag, ".wafull"},    32'(wafull),    32'(e.af));
        check_val({e.tag, ".wovf"},      32'(wovf),      32'(e.ov));
`ifdef WPTR_LEVEL_CHECK_EN
        check_val({e.tag, ".wlvl_err"},  32'(wlvl_err),  32'(e.er));
`endif
        $display("txn %s: rg=%b rb=%0d lvl=%0d free=%0d af=%b ovf=%b",
                 e.tag, rptr_wclk, rbin_wclk, wlevel, wfree, wafull, wovf);
    endtask

    // One registered level evaluation in the reference: modular difference,
    // optional saturation, then hysteresis on the resulting level.
    task automatic model_level(input int w, input int r);
        int lv;
        lv = (w - r) & ((1 << PW) - 1);
`ifdef WPTR_LEVEL_CHECK_EN
        if (lv > DEPTH) begin
            lv   = DEPTH;
            m_er = 1'b1;
        end
`endif
        if (lv >= SET)      m_af = 1'b1;
        else if (lv <= CLR) m_af = 1'b0;
        m_lvl = lv;
    endtask

    // Drive both pointers; the new wptr is seen one edge later while the old
    // synchronized rptr is still in use, then the new rptr lands SS+1 edges in.
    task automatic set_ptrs(input string tag, input int wb, input int rb);
        @(negedge wclk);
        wptr_gray = bin2gray(wb);
        rptr_gray = bin2gray(rb);
        m_w = wb;
        model_level(m_w, m_r);
        m_r = rb;
        model_level(m_w, m_r);
        push_model(tag);
        repeat (SS + 1) @(posedge wclk);
        #1;
        pop_check();
    endtask

    task automatic ovf_step(input string tag, input bit push, input bit full, input bit clr);
        @(negedge wclk);
        wpush    = push;
        wfull    = full;
        wovf_clr = clr;
        if (push && full) m_ov = 1'b1;
        else if (clr)     m_ov = 1'b0;
        push_model(tag);
        @(posedge wclk);
        #1;
        pop_check();
        @(negedge wclk);
        wpush    = 1'b0;
        wfull    = 1'b0;
        wovf_clr = 1'b0;
    endtask

    initial begin
        wrst      = 1'b1;
        rptr_gray = '0;
        wptr_gray = '0;
        wpush     = 1'b0;
        wfull     = 1'b0;
        wovf_clr  = 1'b0;

        // Reset state
        repeat (3) @(posedge wclk);
        #1;
        sb.push_back(mk("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0));
        pop_check();
        @(negedge wclk);
        wrst = 1'b0;

        // Basic level
        set_ptrs("lvl5", 5, 0);

        // Synchronizer latency, one expectation per edge
        @(negedge wclk);
        rptr_gray = bin2gray(3);
        sb.push_back(mk("lat_e1", 0, 0, 5, m_af, m_ov, m_er));
        sb.push_back(mk("lat_e2", 2, 0, 5, m_af, m_ov, m_er));
        sb.push_back(mk("lat_e3", 2, 3, 2, m_af, m_ov, m_er));
        for (int k = 0; k < 3; k++) begin
            @(posedge wclk);
            #1;
            pop_check();
        end
        m_r = 3;
        model_level(m_w, m_r);

        // Hysteresis
        set_ptrs("af_set12", 12, 0);
        set_ptrs("af_hold9", 12, 3);
        set_ptrs("af_clr8",  12, 4);
        set_ptrs("af_low11", 12, 1);

        // Pointer wrap
        set_ptrs("wrap6", 2, 28);

        // Sticky overflow
        ovf_step("ovf_set",     1'b1, 1'b1, 1'b0);
        ovf_step("ovf_hold",    1'b0, 1'b0, 1'b0);
        ovf_step("ovf_clr",     1'b0, 1'b0, 1'b1);
        ovf_step("ovf_nofull",  1'b1, 1'b0, 1'b0);
        ovf_step("ovf_setwins", 1'b1, 1'b1, 1'b1);

        // Move to a high level so wafull is set before the reset test
        set_ptrs("pre2",   2, 0);
        set_ptrs("af14",  14, 0);

`ifdef WPTR_LEVEL_CHECK_EN
        set_ptrs("lvl_err", 20, 0);
`endif

        // Asynchronous reset between edges, with wovf and wafull set
        @(negedge wclk);
        #2;
        wrst = 1'b1;
        #1;
        m_w = 0; m_r = 0; m_lvl = 0;
        m_af = 1'b0; m_ov = 1'b0; m_er = 1'b0;
        sb.push_back(mk("async_rst", 0, 0, 0, 1'b0, 1'b0, 1'b0));
        pop_check();
        wptr_gray = '0;
        rptr_gray = '0;
        repeat (2) @(posedge wclk);
        #1;
        push_model("rst_held");
        pop_check();
        @(negedge wclk);
        wrst = 1'b0;

        set_ptrs("post_rst", 7, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
